// File: rtl/bcd_input_frontend.sv
// Input conditioning for the BCD up/down counter: per-bit synchronisers, three debounce
// channels, a one-pulse-per-press enter FSM and the count-enable tick prescaler.

module bcd_debounce #(
  parameter int WIDTH     = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] synced,
  input  logic [WIDTH-1:0] incoming,
  output logic [WIDTH-1:0] stable
);
  localparam int CW = $clog2(DB_CYCLES);

  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] stable_reg;

  // incoming is the value synced takes next cycle, so a mismatch restarts the count
  // in the same cycle the synced word actually moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      stable_reg <= '0;
    end else if ((synced == stable_reg) || (incoming != synced)) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CW'(DB_CYCLES - 1)) begin
      stable_reg <= synced;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign stable = stable_reg;
endmodule

module bcd_input_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int TICK_DIV    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enter_i,
  input  logic       sw_mode_i,
  input  logic [3:0] sw_load_i,
  output logic       enter,
  output logic       mode,
  output logic [3:0] load,
  output logic       tick
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

  // Bit layout: [0] enter button, [1] mode switch, [5:2] load switches.
  logic [5:0] raw;
  logic [5:0] synced;
  logic [5:0] incoming;

  assign raw = {sw_load_i, sw_mode_i, btn_enter_i};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) chain_reg <= '0;
        else     chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw[gi]};
      end

      assign synced[gi]   = chain_reg[SYNC_STAGES-1];
      assign incoming[gi] = chain_reg[SYNC_STAGES-2];
    end
  endgenerate

  logic       enter_stable;
  logic       mode_stable;
  logic [3:0] load_stable;

  bcd_debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES)) u_db_enter (
    .clk      (clk),
    .rst      (rst),
    .synced   (synced[0]),
    .incoming (incoming[0]),
    .stable   (enter_stable)
  );

  bcd_debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk      (clk),
    .rst      (rst),
    .synced   (synced[1]),
    .incoming (incoming[1]),
    .stable   (mode_stable)
  );

  bcd_debounce #(.WIDTH(4), .DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk      (clk),
    .rst      (rst),
    .synced   (synced[5:2]),
    .incoming (incoming[5:2]),
    .stable   (load_stable)
  );

  logic       mode_reg;
  logic [3:0] load_reg;

  // Non-BCD switch settings are clamped so the counter only ever sees 0..9.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg <= 1'b0;
      load_reg <= 4'd0;
    end else begin
      mode_reg <= mode_stable;
      load_reg <= (load_stable > 4'd9) ? 4'd9 : load_stable;
    end
  end

  state_t state_reg;
  logic   enter_reg;
  logic   press_start;

  assign press_start = (state_reg == IDLE) && enter_stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      enter_reg <= 1'b0;
    end else begin
      enter_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (press_start) begin
            state_reg <= PRESS;
            enter_reg <= 1'b1;
          end
        end
        PRESS:   state_reg <= HELD;
        HELD:    if (!enter_stable) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [PW-1:0] cnt_reg;
  logic          tick_reg;

  // Restarting on the press keeps enter and tick exclusive and gives a full period
  // before the first count step after a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (press_start) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (cnt_reg == PW'(TICK_DIV - 1));
      cnt_reg  <= (cnt_reg == PW'(TICK_DIV - 1)) ? '0 : cnt_reg + PW'(1);
    end
  end

  assign enter = enter_reg;
  assign mode  = mode_reg;
  assign load  = load_reg;
  assign tick  = tick_reg;
endmodule
